zp_mem_fill_arbiter: RTL and testbench

Round-robin arbiter that shares the single 64-bit BedRock memory fill port between `num_req_p` core-side requesters in multicore ZynqParrot builds (34-bit physical address, 64-bit fill width). Each granted transaction is one header plus optional data beats, sent atomically to the memory side. Memory responses return in order. An ID FIFO routes each response stream back to its originating requester. The block sits between the per-core memory command streams and the host/DRAM bridge.

---
 rtl/zp_mem_fill_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_zp_mem_fill_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zp_mem_fill_arbiter.sv
// Round-robin arbiter sharing one BedRock memory fill port; header +1 cycle, data and response
// combinational. Granted transactions lock the port until done; responses steer by an ID FIFO head.

module zp_mem_fill_id_fifo #(
  parameter int width_p = 1,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, rd_ptr_q;
  logic [ptr_w_lp:0]   count_q;
  logic                push_ok, pop_ok;

  assign full_o  = (count_q == (ptr_w_lp+1)'(els_p));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign pop_ok  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO is still legal.
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok != pop_ok) count_q <= push_ok ? count_q + 1'b1 : count_q - 1'b1;
    end
  end
endmodule

module zp_mem_fill_arbiter #(
  parameter int num_req_p     = 2,
  parameter int hdr_width_p   = 64,
  parameter int data_width_p  = 64,
  parameter int id_fifo_els_p = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p*hdr_width_p-1:0]  req_hdr_i,
  input  logic [num_req_p-1:0]              req_has_data_i,
  input  logic [num_req_p-1:0]              req_hdr_v_i,
  output logic [num_req_p-1:0]              req_hdr_ready_and_o,
  input  logic [num_req_p*data_width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]              req_data_v_i,
  input  logic [num_req_p-1:0]              req_last_i,
  output logic [num_req_p-1:0]              req_data_ready_and_o,
  output logic [hdr_width_p-1:0]            mem_hdr_o,
  output logic                              mem_hdr_v_o,
  input  logic                              mem_hdr_ready_and_i,
  output logic [data_width_p-1:0]           mem_data_o,
  output logic                              mem_data_v_o,
  output logic                              mem_last_o,
  input  logic                              mem_data_ready_and_i,
  input  logic [data_width_p-1:0]           mem_resp_data_i,
  input  logic                              mem_resp_v_i,
  input  logic                              mem_resp_last_i,
  output logic                              mem_resp_ready_and_o,
  output logic [data_width_p-1:0]           resp_data_o,
  output logic [num_req_p-1:0]              resp_v_o,
  output logic                              resp_last_o,
  input  logic [num_req_p-1:0]              resp_ready_and_i
);
  localparam int id_w_lp = $clog2(num_req_p);

  localparam logic [1:0] E_IDLE = 2'd0;
  localparam logic [1:0] E_HDR  = 2'd1;
  localparam logic [1:0] E_DATA = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [id_w_lp-1:0]      grant_q, grant_d;
  logic [id_w_lp-1:0]      rr_ptr_q, rr_ptr_d;
  logic [hdr_width_p-1:0]  hdr_arr  [num_req_p];
  logic [data_width_p-1:0] data_arr [num_req_p];

  logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [id_w_lp-1:0]      fifo_head;
  logic                    hdr_hs, data_hs;
  logic                    pick_v;
  logic [id_w_lp-1:0]      pick_idx, grant_next;
  logic [id_w_lp:0]        cand;

  for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
    assign hdr_arr[g]  = req_hdr_i[g*hdr_width_p +: hdr_width_p];
    assign data_arr[g] = req_data_i[g*data_width_p +: data_width_p];
  end

  // Scan offsets from far to near so the requester closest to rr_ptr wins.
  always_comb begin
    pick_v   = |req_hdr_v_i;
    pick_idx = '0;
    cand     = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + (id_w_lp+1)'(i);
      if (cand >= (id_w_lp+1)'(num_req_p)) cand = cand - (id_w_lp+1)'(num_req_p);
      if (req_hdr_v_i[cand[id_w_lp-1:0]]) pick_idx = cand[id_w_lp-1:0];
    end
  end

  assign grant_next = (grant_q == id_w_lp'(num_req_p - 1)) ? '0 : grant_q + 1'b1;
  assign hdr_hs     = (state_q == E_HDR) & req_hdr_v_i[grant_q] & mem_hdr_ready_and_i;
  assign data_hs    = (state_q == E_DATA) & req_data_v_i[grant_q] & mem_data_ready_and_i;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      E_IDLE: begin
        if (pick_v && !fifo_full) begin
          grant_d = pick_idx;
          state_d = E_HDR;
        end
      end
      E_HDR: begin
        if (hdr_hs) begin
          rr_ptr_d = grant_next;
          state_d  = req_has_data_i[grant_q] ? E_DATA : E_IDLE;
        end
      end
      E_DATA: begin
        if (data_hs && req_last_i[grant_q]) state_d = E_IDLE;
      end
      default: state_d = E_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= E_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    req_hdr_ready_and_o  = '0;
    req_data_ready_and_o = '0;
    if (state_q == E_HDR)  req_hdr_ready_and_o[grant_q]  = mem_hdr_ready_and_i;
    if (state_q == E_DATA) req_data_ready_and_o[grant_q] = mem_data_ready_and_i;
  end

  assign mem_hdr_o    = hdr_arr[grant_q];
  assign mem_hdr_v_o  = (state_q == E_HDR) & req_hdr_v_i[grant_q];
  assign mem_data_o   = data_arr[grant_q];
  assign mem_data_v_o = (state_q == E_DATA) & req_data_v_i[grant_q];
  assign mem_last_o   = (state_q == E_DATA) & req_last_i[grant_q];

  // Responses return in order, so the FIFO head is always the owner of the current stream.
  assign fifo_push            = hdr_hs;
  assign mem_resp_ready_and_o = ~fifo_empty & resp_ready_and_i[fifo_head];
  assign fifo_pop             = mem_resp_v_i & mem_resp_ready_and_o & mem_resp_last_i;
  assign resp_data_o          = mem_resp_data_i;
  assign resp_last_o          = mem_resp_last_i & ~fifo_empty;

  always_comb begin
    resp_v_o            = '0;
    resp_v_o[fifo_head] = mem_resp_v_i & ~fifo_empty;
  end

  zp_mem_fill_id_fifo #(
    .width_p (id_w_lp),
    .els_p   (id_fifo_els_p)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (fifo_push),
    .data_i    (grant_q),
    .pop_i     (fifo_pop),
    .data_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );
endmodule

// File: tb/tb_zp_mem_fill_arbiter.sv
// Bench for zp_mem_fill_arbiter: arbitration table, directed corner sequences, randomized traffic
// checked against a transaction-level model (strict round-robin order, burst atomicity, in-order routing).

module tb_zp_mem_fill_arbiter;
  localparam int N  = 2;
  localparam int HW = 64;
  localparam int DW = 64;
  localparam int FE = 4;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic [N*HW-1:0] req_hdr_i;
  logic [N-1:0]    req_has_data_i, req_hdr_v_i, req_hdr_ready_and_o;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]    req_data_v_i, req_last_i, req_data_ready_and_o;
  logic [HW-1:0]   mem_hdr_o;
  logic            mem_hdr_v_o, mem_hdr_ready_and_i;
  logic [DW-1:0]   mem_data_o;
  logic            mem_data_v_o, mem_last_o, mem_data_ready_and_i;
  logic [DW-1:0]   mem_resp_data_i;
  logic            mem_resp_v_i, mem_resp_last_i, mem_resp_ready_and_o;
  logic [DW-1:0]   resp_data_o;
  logic [N-1:0]    resp_v_o, resp_ready_and_i;
  logic            resp_last_o;

  always #5 clk_i = ~clk_i;

  zp_mem_fill_arbiter #(
    .num_req_p(N), .hdr_width_p(HW), .data_width_p(DW), .id_fifo_els_p(FE)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_hdr_i(req_hdr_i), .req_has_data_i(req_has_data_i), .req_hdr_v_i(req_hdr_v_i),
    .req_hdr_ready_and_o(req_hdr_ready_and_o),
    .req_data_i(req_data_i), .req_data_v_i(req_data_v_i), .req_last_i(req_last_i),
    .req_data_ready_and_o(req_data_ready_and_o),
    .mem_hdr_o(mem_hdr_o), .mem_hdr_v_o(mem_hdr_v_o), .mem_hdr_ready_and_i(mem_hdr_ready_and_i),
    .mem_data_o(mem_data_o), .mem_data_v_o(mem_data_v_o), .mem_last_o(mem_last_o),
    .mem_data_ready_and_i(mem_data_ready_and_i),
    .mem_resp_data_i(mem_resp_data_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_last_i(mem_resp_last_i),
    .mem_resp_ready_and_o(mem_resp_ready_and_o),
    .resp_data_o(resp_data_o), .resp_v_o(resp_v_o), .resp_last_o(resp_last_o),
    .resp_ready_and_i(resp_ready_and_i)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk_hdr(input int r, input int k);
    return {8'hA0, 24'(r), 32'(k)};
  endfunction
  function automatic logic [63:0] mk_beat(input int r, input int t, input int b);
    return {8'hD0, 8'(r), 16'(t), 32'(b)};
  endfunction
  function automatic logic [63:0] mk_rsp(input int id, input int s, input int b);
    return {8'hE0, 8'(id), 16'(s), 32'(b)};
  endfunction

  task automatic idle_inputs();
    req_hdr_i = '0; req_has_data_i = '0; req_hdr_v_i = '0;
    req_data_i = '0; req_data_v_i = '0; req_last_i = '0;
    mem_hdr_ready_and_i = 1'b0; mem_data_ready_and_i = 1'b0;
    mem_resp_data_i = '0; mem_resp_v_i = 1'b0; mem_resp_last_i = 1'b0;
    resp_ready_and_i = '1;
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    idle_inputs();
    @(posedge clk_i);
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
  endtask

  task automatic next_cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_mem_hdr_v"}, mem_hdr_v_o, 0);
    chk({tag, "_mem_data_v"}, mem_data_v_o, 0);
    chk({tag, "_mem_last"}, mem_last_o, 0);
    chk({tag, "_req_hdr_rdy"}, req_hdr_ready_and_o, 0);
    chk({tag, "_req_data_rdy"}, req_data_ready_and_o, 0);
    chk({tag, "_mem_resp_rdy"}, mem_resp_ready_and_o, 0);
    chk({tag, "_resp_v"}, resp_v_o, 0);
    chk({tag, "_resp_last"}, resp_last_o, 0);
  endtask

  typedef struct {
    logic [1:0] vld;
    int         exp_gnt;
  } arb_vec_t;
  arb_vec_t vecs [8];

  // Random-phase model state
  logic [63:0] cur_hdr [N];
  bit          cur_has [N];
  int          cur_nb  [N];
  int          cur_b   [N];
  bit          in_data [N];
  int          txn_cnt [N];
  int          rsp_id_q [$];
  int          rsp_nb_q [$];
  int          rsp_b, rsp_seq, exp_gnt, hdr_cnt, owner;
  bit          rsp_active;

  task automatic new_txn(input int r);
    txn_cnt[r]++;
    cur_hdr[r] = mk_hdr(r, 1000 + txn_cnt[r]);
    cur_has[r] = ($urandom_range(0, 1) == 1);
    cur_nb[r]  = $urandom_range(1, 4);
    cur_b[r]   = 0;
    in_data[r] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, rb, got;

    // Reset state with every input active
    reset_n_i = 1'b0;
    idle_inputs();
    req_hdr_v_i = '1; req_data_v_i = '1; req_last_i = '1;
    mem_hdr_ready_and_i = 1'b1; mem_data_ready_and_i = 1'b1;
    mem_resp_v_i = 1'b1; mem_resp_last_i = 1'b1;
    #2;
    chk_all_quiet("reset");
    do_reset();

    // Arbitration table: header-only requests, each followed by a 1-beat response
    vecs[0] = '{2'b10, 1};
    vecs[1] = '{2'b11, 0};
    vecs[2] = '{2'b11, 1};
    vecs[3] = '{2'b01, 0};
    vecs[4] = '{2'b10, 1};
    vecs[5] = '{2'b10, 1};
    vecs[6] = '{2'b11, 0};
    vecs[7] = '{2'b11, 1};
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < N; r++) req_hdr_i[r*HW +: HW] = mk_hdr(r, k);
      req_has_data_i = '0;
      req_hdr_v_i = vecs[k].vld;
      mem_hdr_ready_and_i = 1'b1;
      @(negedge clk_i);
      chk("tbl_hdr_v_t0", mem_hdr_v_o, 0);
      next_cyc();
      @(negedge clk_i);
      chk("tbl_hdr_v_t1", mem_hdr_v_o, 1);
      chk("tbl_hdr", mem_hdr_o, mk_hdr(vecs[k].exp_gnt, k));
      chk("tbl_hdr_rdy", req_hdr_ready_and_o, 64'(1 << vecs[k].exp_gnt));
      next_cyc();
      req_hdr_v_i = '0;
      mem_resp_v_i = 1'b1; mem_resp_last_i = 1'b1;
      mem_resp_data_i = 64'hDEAD + 64'(k);
      resp_ready_and_i = '1;
      @(negedge clk_i);
      chk("tbl_resp_v", resp_v_o, 64'(1 << vecs[k].exp_gnt));
      chk("tbl_resp_data", resp_data_o, 64'hDEAD + 64'(k));
      chk("tbl_mem_resp_rdy", mem_resp_ready_and_o, 1);
      next_cyc();
      mem_resp_v_i = 1'b0; mem_resp_last_i = 1'b0;
    end
    @(negedge clk_i);
    chk("tbl_drained_resp_v", resp_v_o, 0);
    next_cyc();

    // Write burst lock: requester 1 waits until requester 0's burst completes
    do_reset();
    req_hdr_i[0 +: HW] = mk_hdr(0, 100);
    req_hdr_i[HW +: HW] = mk_hdr(1, 101);
    req_has_data_i = 2'b01; req_hdr_v_i = 2'b11;
    mem_hdr_ready_and_i = 1'b1;
    next_cyc();
    @(negedge clk_i);
    chk("burst_hdr_v", mem_hdr_v_o, 1);
    chk("burst_hdr", mem_hdr_o, mk_hdr(0, 100));
    next_cyc();
    req_hdr_v_i = 2'b10;
    b = 1;
    for (int c = 0; c < 5; c++) begin
      req_data_i[0 +: DW] = 64'(b);
      req_data_v_i = 2'b01;
      req_last_i = (b == 4) ? 2'b01 : 2'b00;
      mem_data_ready_and_i = (c != 1);
      @(negedge clk_i);
      chk("burst_data_v", mem_data_v_o, 1);
      chk("burst_data", mem_data_o, 64'(b));
      chk("burst_last", mem_last_o, (b == 4));
      chk("burst_data_rdy", req_data_ready_and_o, (c != 1) ? 2'b01 : 2'b00);
      chk("burst_no_hdr", mem_hdr_v_o, 0);
      next_cyc();
      if (c != 1) b++;
    end
    req_data_v_i = '0; req_last_i = '0;
    @(negedge clk_i);
    chk("lock_idle_hdr_v", mem_hdr_v_o, 0);
    next_cyc();
    @(negedge clk_i);
    chk("lock_r1_hdr_v", mem_hdr_v_o, 1);
    chk("lock_r1_hdr", mem_hdr_o, mk_hdr(1, 101));
    next_cyc();
    req_hdr_v_i = '0;

    // Response backpressure: FIFO holds {0,1}
    mem_resp_v_i = 1'b1; mem_resp_last_i = 1'b1; mem_resp_data_i = 64'h1111;
    @(negedge clk_i);
    chk("bp_r0_resp_v", resp_v_o, 2'b01);
    chk("bp_r0_mem_rdy", mem_resp_ready_and_o, 1);
    next_cyc();
    rb = 0;
    for (int c = 0; c < 5; c++) begin
      resp_ready_and_i = (c < 3) ? 2'b01 : 2'b11;
      mem_resp_data_i = 64'h2221 + 64'(rb);
      mem_resp_last_i = (rb == 1);
      @(negedge clk_i);
      chk("bp_r1_resp_v", resp_v_o, 2'b10);
      chk("bp_r1_mem_rdy", mem_resp_ready_and_o, (c >= 3));
      chk("bp_r1_data", resp_data_o, 64'h2221 + 64'(rb));
      chk("bp_r1_last", resp_last_o, (rb == 1));
      next_cyc();
      if (c >= 3) rb++;
    end
    @(negedge clk_i);
    chk("bp_empty_mem_rdy", mem_resp_ready_and_o, 0);
    chk("bp_empty_resp_v", resp_v_o, 0);
    next_cyc();
    mem_resp_v_i = 1'b0; mem_resp_last_i = 1'b0;

    // FIFO full: four outstanding headers block the fifth until one response completes
    do_reset();
    req_hdr_i[0 +: HW] = mk_hdr(0, 200);
    req_hdr_v_i = 2'b01; mem_hdr_ready_and_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      next_cyc();
      @(negedge clk_i);
      chk("full_fill_hdr_v", mem_hdr_v_o, 1);
      chk("full_fill_hdr", mem_hdr_o, mk_hdr(0, 200 + k));
      next_cyc();
      req_hdr_i[0 +: HW] = mk_hdr(0, 201 + k);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk("full_blocked_hdr_v", mem_hdr_v_o, 0);
      next_cyc();
    end
    mem_resp_v_i = 1'b1; mem_resp_last_i = 1'b1; mem_resp_data_i = 64'h3333;
    @(negedge clk_i);
    chk("full_resp_v", resp_v_o, 2'b01);
    chk("full_mem_resp_rdy", mem_resp_ready_and_o, 1);
    next_cyc();
    mem_resp_v_i = 1'b0; mem_resp_last_i = 1'b0;
    got = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      if (mem_hdr_v_o) begin
        got = 1;
        chk("full_release_hdr", mem_hdr_o, mk_hdr(0, 204));
        break;
      end
      next_cyc();
    end
    chk("full_release_within_3", got, 1);
    next_cyc();
    req_hdr_v_i = '0;

    // Reset mid-burst
    do_reset();
    req_hdr_i[HW +: HW] = mk_hdr(1, 300);
    req_has_data_i = 2'b10; req_hdr_v_i = 2'b10;
    mem_hdr_ready_and_i = 1'b1; mem_data_ready_and_i = 1'b1;
    next_cyc();
    @(negedge clk_i);
    chk("rstb_hdr_v", mem_hdr_v_o, 1);
    next_cyc();
    req_hdr_v_i = 2'b11;
    req_data_i[DW +: DW] = 64'h55; req_data_v_i = 2'b10; req_last_i = '0;
    mem_resp_v_i = 1'b1; mem_resp_last_i = 1'b1;
    @(negedge clk_i);
    chk("rstb_data_v", mem_data_v_o, 1);
    chk("rstb_data_rdy", req_data_ready_and_o, 2'b10);
    #1 reset_n_i = 1'b0;
    #1;
    chk_all_quiet("rstb");
    next_cyc();
    idle_inputs();
    reset_n_i = 1'b1;
    req_hdr_i[0 +: HW] = mk_hdr(0, 400);
    req_hdr_i[HW +: HW] = mk_hdr(1, 400);
    req_hdr_v_i = 2'b11; mem_hdr_ready_and_i = 1'b1;
    @(negedge clk_i);
    chk("rsta_hdr_v_t0", mem_hdr_v_o, 0);
    next_cyc();
    @(negedge clk_i);
    chk("rsta_hdr_v_t1", mem_hdr_v_o, 1);
    chk("rsta_first_grant", mem_hdr_o, mk_hdr(0, 400));
    next_cyc();
    req_hdr_v_i = '0;

    // Randomized traffic against the transaction model
    do_reset();
    for (int r = 0; r < N; r++) begin
      txn_cnt[r] = 0;
      new_txn(r);
    end
    rsp_id_q.delete(); rsp_nb_q.delete();
    rsp_b = 0; rsp_seq = 0; rsp_active = 1'b0; exp_gnt = 0; hdr_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int r = 0; r < N; r++) begin
        req_hdr_i[r*HW +: HW] = cur_hdr[r];
        req_has_data_i[r] = cur_has[r];
        req_hdr_v_i[r] = !in_data[r];
        if (!in_data[r]) req_data_v_i[r] = 1'b0;
        else if (!req_data_v_i[r]) req_data_v_i[r] = ($urandom_range(0, 3) != 0);
        req_data_i[r*DW +: DW] = mk_beat(r, txn_cnt[r], cur_b[r]);
        req_last_i[r] = (cur_b[r] == cur_nb[r] - 1);
      end
      mem_hdr_ready_and_i = ($urandom_range(0, 2) != 0);
      mem_data_ready_and_i = ($urandom_range(0, 2) != 0);
      if (!rsp_active && rsp_id_q.size() > 0 && $urandom_range(0, 1) == 1) rsp_active = 1'b1;
      mem_resp_v_i = rsp_active;
      mem_resp_data_i = (rsp_id_q.size() > 0) ? mk_rsp(rsp_id_q[0], rsp_seq, rsp_b) : '0;
      mem_resp_last_i = (rsp_nb_q.size() > 0) ? (rsp_b == rsp_nb_q[0] - 1) : 1'b0;
      resp_ready_and_i = N'($urandom_range(0, (1 << N) - 1));

      @(negedge clk_i);
      owner = -1;
      for (int r = 0; r < N; r++) if (in_data[r]) owner = r;

      chk("rnd_data_v", mem_data_v_o, (owner >= 0) ? req_data_v_i[owner] : 1'b0);
      chk("rnd_data_rdy", req_data_ready_and_o,
          (owner >= 0) ? 64'(mem_data_ready_and_i) << owner : 64'd0);
      if (owner >= 0 && mem_data_v_o && mem_data_ready_and_i) begin
        chk("rnd_data", mem_data_o, mk_beat(owner, txn_cnt[owner], cur_b[owner]));
        chk("rnd_last", mem_last_o, (cur_b[owner] == cur_nb[owner] - 1));
        if (cur_b[owner] == cur_nb[owner] - 1) new_txn(owner);
        else cur_b[owner]++;
      end

      if (mem_hdr_v_o && mem_hdr_ready_and_i) begin
        chk("rnd_hdr", mem_hdr_o, cur_hdr[exp_gnt]);
        chk("rnd_hdr_rdy", req_hdr_ready_and_o, 64'(1 << exp_gnt));
        rsp_id_q.push_back(exp_gnt);
        rsp_nb_q.push_back($urandom_range(1, 3));
        if (cur_has[exp_gnt]) in_data[exp_gnt] = 1'b1;
        else new_txn(exp_gnt);
        exp_gnt = (exp_gnt + 1) % N;
        hdr_cnt++;
      end

      if (mem_resp_v_i) begin
        chk("rnd_resp_v", resp_v_o, 64'(1 << rsp_id_q[0]));
        chk("rnd_mem_resp_rdy", mem_resp_ready_and_o, resp_ready_and_i[rsp_id_q[0]]);
        chk("rnd_resp_data", resp_data_o, mk_rsp(rsp_id_q[0], rsp_seq, rsp_b));
        chk("rnd_resp_last", resp_last_o, mem_resp_last_i);
        if (mem_resp_ready_and_o) begin
          if (mem_resp_last_i) begin
            void'(rsp_id_q.pop_front());
            void'(rsp_nb_q.pop_front());
            rsp_b = 0; rsp_seq++; rsp_active = 1'b0;
          end else begin
            rsp_b++;
          end
        end
      end else begin
        chk("rnd_resp_v_idle", resp_v_o, 0);
      end
      next_cyc();
    end
    chk("rnd_progress", (hdr_cnt >= 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
